mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the pipeline's two memory requesters: instruction fetch (IF, read-only) and the MEM-stage data access (DM, load/store).
- Sequences each access as a registered request/ready transaction and returns read data with a one-cycle done pulse.
- Drives a global stall to the pipeline while any request is outstanding.
- Detects a non-responding memory by timeout and flags it.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (IF, read-only)
// and the MEM-stage data access (DM, load/store). Each access is a registered
// request/ready transaction: IDLE -> BUSY (mem_req held) -> RESP (done pulse)
// -> IDLE. DM has fixed priority. A memory that never answers is aborted
// after TIMEOUT busy cycles and flagged on the sticky bus_err.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   if_req/if_addr       fetch request (level, held until if_done) and address
//   if_rdata/if_done     fetched word and its one-cycle completion pulse
//   dm_req/dm_we         data request (level) and store select
//   dm_addr/dm_wdata     data address and store data
//   dm_ctrl              size/sign code, forwarded unchanged to mem_ctrl
//   dm_rdata/dm_done     load data and its one-cycle completion pulse
//   mem_req/mem_we       memory transaction valid / write enable
//   mem_addr/mem_wdata   memory address / write data
//   mem_ctrl             memory size code
//   mem_rdata/mem_ready  memory read data and completion (sampled in BUSY)
//   stall                combinational pipeline stall
//   bus_err              sticky timeout flag
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       CTRL_WORD = 3'b010;

  state_t           state;
  logic             owner_dm;
  logic [CNT_W-1:0] cnt;

  // Word returned to the owner at completion: stores and timeouts return 0.
  function automatic logic [31:0] resp_data(input logic ready, input logic we,
                                            input logic [31:0] rdata);
    return (ready && !we) ? rdata : 32'd0;
  endfunction

  logic        finish;
  logic [31:0] rsp_word;

  assign finish   = mem_ready || (cnt == CNT_LAST);
  assign rsp_word = resp_data(mem_ready, mem_we, mem_rdata);

  // Stall holds while a requester has not yet seen its done pulse.
  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      cnt       <= '0;
      if_rdata  <= 32'd0;
      if_done   <= 1'b0;
      dm_rdata  <= 32'd0;
      dm_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_ctrl  <= 3'd0;
      bus_err   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req) begin
            owner_dm  <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_ctrl  <= dm_ctrl;
            cnt       <= '0;
            state     <= BUSY;
          end else if (if_req) begin
            owner_dm  <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'd0;
            mem_ctrl  <= CTRL_WORD;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (finish) begin
            if (owner_dm) begin
              dm_rdata <= rsp_word;
              dm_done  <= 1'b1;
            end else begin
              if_rdata <= rsp_word;
              if_done  <= 1'b1;
            end
            // A ready arriving on the last allowed cycle still counts as success.
            if (!mem_ready) bus_err <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_ctrl  <= 3'd0;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_ctrl  <= 3'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ctrl   (dm_ctrl),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ctrl  (mem_ctrl),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] fetch_data [3];

  initial begin
    fetch_data[0] = 32'h0000_0013;
    fetch_data[1] = 32'h0041_0113;
    fetch_data[2] = 32'h0082_0193;

    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_ctrl = 3'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_dm_done", 32'(dm_done), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    step();

    // Single fetch, zero-wait memory
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1 check("f1_stall_req", 32'(stall), 32'd1);
    step();
    check("f1_mem_req", 32'(mem_req), 32'd1);
    check("f1_mem_addr", mem_addr, 32'h40);
    check("f1_mem_we", 32'(mem_we), 32'd0);
    check("f1_mem_ctrl", 32'(mem_ctrl), 32'd2);
    mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    step();
    check("f1_if_done", 32'(if_done), 32'd1);
    check("f1_if_rdata", if_rdata, 32'h0010_0093);
    check("f1_mem_req_off", 32'(mem_req), 32'd0);
    check("f1_stall_off", 32'(stall), 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    check("f1_done_pulse", 32'(if_done), 32'd0);
    check("f1_idle_req", 32'(mem_req), 32'd0);

    // Store with three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_ctrl = 3'b010;
    step();
    for (int i = 0; i < 4; i++) begin
      check("st_mem_req", 32'(mem_req), 32'd1);
      check("st_mem_we", 32'(mem_we), 32'd1);
      check("st_mem_addr", mem_addr, 32'h100);
      check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_mem_ctrl", 32'(mem_ctrl), 32'd2);
      check("st_no_early_done", 32'(dm_done), 32'd0);
      check("st_stall", 32'(stall), 32'd1);
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
      end
      step();
    end
    check("st_dm_done", 32'(dm_done), 32'd1);
    check("st_dm_rdata", dm_rdata, 32'd0);
    check("st_if_done", 32'(if_done), 32'd0);
    check("st_mem_we_off", 32'(mem_we), 32'd0);
    check("st_mem_wdata_off", mem_wdata, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    step();
    check("st_done_pulse", 32'(dm_done), 32'd0);

    // Contention: DM load first, then IF
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_ctrl = 3'b100;
    if_req = 1'b1; if_addr = 32'h44;
    step();
    check("ct_dm_addr", mem_addr, 32'h200);
    check("ct_dm_ctrl", 32'(mem_ctrl), 32'd4);
    check("ct_dm_we", 32'(mem_we), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    check("ct_dm_done", 32'(dm_done), 32'd1);
    check("ct_if_not_done", 32'(if_done), 32'd0);
    check("ct_dm_rdata", dm_rdata, 32'h1234_5678);
    check("ct_stall_if_wait", 32'(stall), 32'd1);
    dm_req = 1'b0; mem_ready = 1'b0;
    step();
    check("ct_idle_req", 32'(mem_req), 32'd0);
    check("ct_idle_dm_done", 32'(dm_done), 32'd0);
    step();
    check("ct_if_addr", mem_addr, 32'h44);
    check("ct_if_ctrl", 32'(mem_ctrl), 32'd2);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    step();
    check("ct_if_done", 32'(if_done), 32'd1);
    check("ct_dm_not_done", 32'(dm_done), 32'd0);
    check("ct_if_rdata", if_rdata, 32'h0000_0013);
    check("ct_dm_rdata_hold", dm_rdata, 32'h1234_5678);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Ready on the last allowed busy cycle wins over timeout
    dm_req = 1'b1; dm_addr = 32'h304; dm_ctrl = 3'b010;
    step();
    for (int i = 0; i < 16; i++) begin
      check("tv_busy", 32'(mem_req), 32'd1);
      check("tv_no_done", 32'(dm_done), 32'd0);
      if (i == 15) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
      step();
    end
    check("tv_dm_done", 32'(dm_done), 32'd1);
    check("tv_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    check("tv_bus_err", 32'(bus_err), 32'd0);
    dm_req = 1'b0; mem_ready = 1'b0;
    step();

    // Timeout: memory never answers
    dm_req = 1'b1; dm_addr = 32'h300;
    step();
    for (int i = 0; i < 16; i++) begin
      check("to_busy", 32'(mem_req), 32'd1);
      check("to_no_done", 32'(dm_done), 32'd0);
      step();
    end
    check("to_dm_done", 32'(dm_done), 32'd1);
    check("to_dm_rdata", dm_rdata, 32'd0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_mem_req_off", 32'(mem_req), 32'd0);
    dm_req = 1'b0;
    step();

    // Normal access after timeout keeps bus_err sticky
    if_req = 1'b1; if_addr = 32'h48;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0073;
    step();
    check("st_err_if_done", 32'(if_done), 32'd1);
    check("st_err_if_rdata", if_rdata, 32'h0000_0073);
    check("st_err_sticky", 32'(bus_err), 32'd1);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Asynchronous reset in the middle of BUSY
    if_req = 1'b1; if_addr = 32'h80;
    step();
    check("rb_busy", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rb_mem_req", 32'(mem_req), 32'd0);
    check("rb_bus_err", 32'(bus_err), 32'd0);
    check("rb_if_done", 32'(if_done), 32'd0);
    check("rb_mem_addr", mem_addr, 32'd0);
    check("rb_if_rdata", if_rdata, 32'd0);
    check("rb_dm_rdata", dm_rdata, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("rb_restart_req", 32'(mem_req), 32'd1);
    check("rb_restart_addr", mem_addr, 32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    step();
    check("rb_if_done2", 32'(if_done), 32'd1);
    check("rb_if_rdata2", if_rdata, 32'h0000_0055);
    mem_ready = 1'b0;

    // Back-to-back fetches with if_req held, memory always ready
    if_addr = 32'h0;
    step();
    check("bb_idle_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = fetch_data[k];
      step();
      check("bb_mem_req", 32'(mem_req), 32'd1);
      check("bb_mem_addr", mem_addr, 32'(4 * k));
      check("bb_no_early_done", 32'(if_done), 32'd0);
      step();
      check("bb_if_done", 32'(if_done), 32'd1);
      check("bb_if_rdata", if_rdata, fetch_data[k]);
      if (k == 2) if_req = 1'b0;
      else if_addr = 32'(4 * (k + 1));
      step();
      check("bb_idle_gap", 32'(mem_req), 32'd0);
      check("bb_done_low", 32'(if_done), 32'd0);
    end
    step();
    check("bb_no_spurious_req", 32'(mem_req), 32'd0);
    check("bb_no_spurious_done", 32'(if_done), 32'd0);
    check("bb_stall_idle", 32'(stall), 32'd0);
    mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
